// File: rtl/z16_mmio_pkg.sv
// Shared register-map constants and address decode for the Z16 MMIO GPIO block.
package z16_mmio_pkg;

  localparam int unsigned OFS_OUT   = 'h0;
  localparam int unsigned OFS_SET   = 'h2;
  localparam int unsigned OFS_CLR   = 'h4;
  localparam int unsigned OFS_IN    = 'h6;
  localparam int unsigned OFS_EDGE  = 'h8;
  localparam int unsigned OFS_IRQEN = 'hA;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_OUT,
    SEL_SET,
    SEL_CLR,
    SEL_IN,
    SEL_EDGE,
    SEL_IRQEN
  } reg_sel_e;

  function automatic reg_sel_e decode_ofs(input logic [3:0] ofs);
    reg_sel_e sel;
    case (ofs)
      4'(OFS_OUT):   sel = SEL_OUT;
      4'(OFS_SET):   sel = SEL_SET;
      4'(OFS_CLR):   sel = SEL_CLR;
      4'(OFS_IN):    sel = SEL_IN;
      4'(OFS_EDGE):  sel = SEL_EDGE;
      4'(OFS_IRQEN): sel = SEL_IRQEN;
      default:       sel = SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/z16_debounce.sv
// Per-input 2-flop synchroniser with optional debounce counter (Z16_MMIO_DEBOUNCE_EN).
// o_rise pulses in the cycle whose clock edge raises o_stable.
module z16_debounce
`ifdef Z16_MMIO_DEBOUNCE_EN
  #(
    parameter int unsigned DB_CYCLES = 50000
  )
`endif
  (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    output logic o_stable,
    output logic o_rise
  );

  logic [1:0] sync_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) sync_q <= '0;
    else          sync_q <= {sync_q[0], i_raw};
  end

`ifdef Z16_MMIO_DEBOUNCE_EN
  localparam int unsigned CNT_W = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sync;

  assign sync = sync_q[1];

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync != stable_q) begin
      if (cnt_q == CNT_LAST) stable_d = sync;
      else                   cnt_d    = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign o_stable = stable_q;
  assign o_rise   = sync & ~stable_q & (cnt_q == CNT_LAST);
`else
  assign o_stable = sync_q[1];
  assign o_rise   = sync_q[0] & ~sync_q[1];
`endif

endmodule

// File: rtl/z16_mmio_gpio.sv
// MMIO GPIO block: OUT/SET/CLR/IN/EDGE/IRQEN register window with edge interrupt.
// Input debouncing is enabled by defining Z16_MMIO_DEBOUNCE_EN.
module z16_mmio_gpio
  import z16_mmio_pkg::*;
#(
  parameter int unsigned             DATA_W    = 16,
  parameter int unsigned             ADDR_W    = 16,
  parameter logic [ADDR_W-1:0]       BASE_ADDR = 16'h0070,
  parameter int unsigned             N_OUT     = 6,
  parameter int unsigned             N_IN      = 1,
  parameter int unsigned             DB_CYCLES = 50000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_wen,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_hit,
  input  logic [N_IN-1:0]   i_gpio,
  output logic [N_OUT-1:0]  o_gpio,
  output logic              o_irq
);

  if (N_OUT < 1 || N_OUT > DATA_W || N_IN < 1 || N_IN > DATA_W || DB_CYCLES < 2) begin : g_bad_cfg
    $error("z16_mmio_gpio: illegal parameter combination");
  end

  logic [ADDR_W-1:0] off;
  reg_sel_e          sel;

  assign off = i_addr - BASE_ADDR;

  always_comb begin
    sel = SEL_NONE;
    if ((off >> 4) == '0) sel = decode_ofs(off[3:0]);
  end

  logic [N_IN-1:0] in_stable;
  logic [N_IN-1:0] in_rise;

  for (genvar k = 0; k < N_IN; k++) begin : g_in
`ifdef Z16_MMIO_DEBOUNCE_EN
    z16_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
`else
    z16_debounce u_db (
`endif
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_raw    (i_gpio[k]),
      .o_stable (in_stable[k]),
      .o_rise   (in_rise[k])
    );
  end

  logic [N_OUT-1:0] out_q, out_d;
  logic [N_IN-1:0]  edge_q, edge_d;
  logic [N_IN-1:0]  irqen_q, irqen_d;

  always_comb begin
    out_d   = out_q;
    edge_d  = edge_q;
    irqen_d = irqen_q;
    if (i_wen) begin
      case (sel)
        SEL_OUT:   out_d   = i_wdata[N_OUT-1:0];
        SEL_SET:   out_d   = out_q | i_wdata[N_OUT-1:0];
        SEL_CLR:   out_d   = out_q & ~i_wdata[N_OUT-1:0];
        SEL_EDGE:  edge_d  = edge_q & ~i_wdata[N_IN-1:0];
        SEL_IRQEN: irqen_d = i_wdata[N_IN-1:0];
        default:   ;
      endcase
    end
    // new edges are OR'd in after the W1C so a coincident set survives
    edge_d = edge_d | in_rise;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      out_q   <= '0;
      edge_q  <= '0;
      irqen_q <= '0;
    end else begin
      out_q   <= out_d;
      edge_q  <= edge_d;
      irqen_q <= irqen_d;
    end
  end

  always_comb begin
    o_rdata = '0;
    case (sel)
      SEL_OUT:   o_rdata = DATA_W'(out_q);
      SEL_IN:    o_rdata = DATA_W'(in_stable);
      SEL_EDGE:  o_rdata = DATA_W'(edge_q);
      SEL_IRQEN: o_rdata = DATA_W'(irqen_q);
      default:   o_rdata = '0;
    endcase
  end

  assign o_hit  = (sel != SEL_NONE);
  assign o_gpio = out_q;
  assign o_irq  = |(edge_q & irqen_q);

  logic unused_wdata;
  assign unused_wdata = ^i_wdata;

endmodule

// File: tb/tb_z16_mmio_gpio.sv
// Directed self-checking bench for z16_mmio_gpio (expected IN latency depends on Z16_MMIO_DEBOUNCE_EN).
module tb_z16_mmio_gpio;

`ifdef Z16_MMIO_DEBOUNCE_EN
  localparam int LAT = 10;
`else
  localparam int LAT = 2;
`endif

  logic        clk;
  logic        rst_n;
  logic [15:0] addr;
  logic        wen;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        hit;
  logic [0:0]  gpio_in;
  logic [5:0]  gpio_out;
  logic        irq;

  int n_checks = 0;
  int n_err    = 0;

  z16_mmio_gpio #(
    .DATA_W    (16),
    .ADDR_W    (16),
    .BASE_ADDR (16'h0070),
    .N_OUT     (6),
    .N_IN      (1),
    .DB_CYCLES (8)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_addr  (addr),
    .i_wen   (wen),
    .i_wdata (wdata),
    .o_rdata (rdata),
    .o_hit   (hit),
    .i_gpio  (gpio_in),
    .o_gpio  (gpio_out),
    .o_irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    addr  = a;
    wdata = d;
    wen   = 1'b1;
    tick();
    wen   = 1'b0;
    wdata = '0;
  endtask

  task automatic rd(input string tag, input logic [15:0] a, input logic [15:0] exp);
    addr = a;
    #1;
    chk(tag, {16'h0, rdata}, {16'h0, exp});
  endtask

  initial begin
    rst_n   = 1'b0;
    addr    = '0;
    wen     = 1'b0;
    wdata   = '0;
    gpio_in = '0;
    @(negedge clk);
    tick();
    chk("rst_gpio", {26'h0, gpio_out}, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    rd("rst_out_rd", 16'h0070, 16'h0000);
    rd("rst_in_rd", 16'h0076, 16'h0000);
    rst_n = 1'b1;

    // OUT write and readback
    wr(16'h0070, 16'h002A);
    chk("out_gpio", {26'h0, gpio_out}, 32'h2A);
    rd("out_rd", 16'h0070, 16'h002A);
    chk("out_hit", {31'h0, hit}, 32'h1);

    // set / clear
    wr(16'h0070, 16'h000F);
    wr(16'h0072, 16'h0030);
    chk("set_gpio", {26'h0, gpio_out}, 32'h3F);
    wr(16'h0074, 16'h0003);
    chk("clr_gpio", {26'h0, gpio_out}, 32'h3C);
    rd("set_rd0", 16'h0072, 16'h0000);
    chk("set_hit", {31'h0, hit}, 32'h1);
    rd("clr_rd0", 16'h0074, 16'h0000);

    // upper bits ignored
    wr(16'h0070, 16'hFFFF);
    rd("out_wide", 16'h0070, 16'h003F);
    wr(16'h0070, 16'h003C);

    // unmapped and read-only addresses
    wr(16'h007C, 16'hFFFF);
    wr(16'h0076, 16'hFFFF);
    wr(16'h0071, 16'hFFFF);
    chk("dec_gpio", {26'h0, gpio_out}, 32'h3C);
    rd("dec_rd7c", 16'h007C, 16'h0000);
    chk("dec_hit7c", {31'h0, hit}, 32'h0);
    rd("dec_in_rd", 16'h0076, 16'h0000);
    rd("dec_rd71", 16'h0071, 16'h0000);
    chk("dec_hit71", {31'h0, hit}, 32'h0);
    rd("dec_edge", 16'h0078, 16'h0000);

    wr(16'h007A, 16'hFFFF);
    rd("irqen_rd", 16'h007A, 16'h0001);
    chk("irq_idle", {31'h0, irq}, 32'h0);

`ifdef Z16_MMIO_DEBOUNCE_EN
    // bouncing input never settles long enough
    for (int i = 0; i < 8; i++) begin
      gpio_in = ~gpio_in;
      repeat (3) tick();
      rd("bounce_in", 16'h0076, 16'h0000);
    end
    gpio_in = 1'b0;
    repeat (4) tick();
`endif

    // held high: IN and EDGE rise together after LAT clocks
    gpio_in = 1'b1;
    for (int i = 1; i <= LAT; i++) begin
      tick();
      if (i >= LAT - 1) begin
        rd("hold_in", 16'h0076, (i == LAT) ? 16'h0001 : 16'h0000);
        rd("hold_edge", 16'h0078, (i == LAT) ? 16'h0001 : 16'h0000);
      end
    end
    chk("irq_set", {31'h0, irq}, 32'h1);

    wr(16'h0078, 16'h0001);
    chk("irq_w1c", {31'h0, irq}, 32'h0);
    rd("edge_w1c", 16'h0078, 16'h0000);

    // falling edge does not set EDGE
    gpio_in = 1'b0;
    repeat (LAT + 2) tick();
    rd("fall_in", 16'h0076, 16'h0000);
    rd("fall_edge", 16'h0078, 16'h0000);

    // W1C coincident with new rising edge: set wins
    gpio_in = 1'b1;
    repeat (LAT - 1) tick();
    wr(16'h0078, 16'h0001);
    rd("race_edge", 16'h0078, 16'h0001);
    chk("race_irq", {31'h0, irq}, 32'h1);
    wr(16'h007A, 16'h0000);
    chk("irq_mask", {31'h0, irq}, 32'h0);

    // reset mid-debounce, with a simultaneous OUT write
    wr(16'h007A, 16'h0001);
    wr(16'h0078, 16'h0001);
    gpio_in = 1'b0;
    repeat (LAT + 2) tick();
    gpio_in = 1'b1;
    repeat (7) tick();
    rst_n = 1'b0;
    addr  = 16'h0070;
    wdata = 16'h003F;
    wen   = 1'b1;
    tick();
    wen   = 1'b0;
    rst_n = 1'b1;
    chk("rst2_gpio", {26'h0, gpio_out}, 32'h0);
    chk("rst2_irq", {31'h0, irq}, 32'h0);
    rd("rst2_in", 16'h0076, 16'h0000);
    rd("rst2_irqen", 16'h007A, 16'h0000);
    rd("rst2_edge", 16'h0078, 16'h0000);
    addr = 16'h0076;
    for (int i = 1; i <= LAT; i++) begin
      tick();
      if (i >= LAT - 1)
        rd("restart_in", 16'h0076, (i == LAT) ? 16'h0001 : 16'h0000);
    end
    rd("restart_edge", 16'h0078, 16'h0001);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
